// File: rtl/dm_mem_bus_decoder.sv
// Slave-side front end of the debug memory region: grants hart bus requests,
// decodes addresses into one-hot datapath strobes and registers the response.
module dm_mem_bus_decoder #(
  parameter int unsigned DbgAddressBits = 12,
  parameter int unsigned DataCount      = 2,
  parameter int unsigned ProgBufSize    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [DbgAddressBits-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                be_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [63:0]               rdata_o,
  output logic                      err_o,
  output logic                      wr_halted_en_o,
  output logic                      wr_going_en_o,
  output logic                      wr_resuming_en_o,
  output logic                      wr_exception_en_o,
  output logic                      wr_data_en_o,
  output logic                      rd_where_en_o,
  output logic                      rd_data_en_o,
  output logic                      rd_prog_en_o,
  output logic                      rd_abs_cmd_en_o,
  output logic                      rd_flags_en_o,
  output logic [DbgAddressBits-1:0] addr_o,
  output logic [31:0]               wdata_o,
  output logic [3:0]                be_o,
  input  logic [63:0]               dp_rdata_i,
  output logic                      exc_sticky_o,
  input  logic                      clr_exc_i
);

  localparam logic [31:0] HALTED_ADDR    = 32'h100;
  localparam logic [31:0] GOING_ADDR     = 32'h108;
  localparam logic [31:0] RESUMING_ADDR  = 32'h110;
  localparam logic [31:0] EXCEPTION_ADDR = 32'h118;
  localparam logic [31:0] WHERE_ADDR     = 32'h300;
  localparam logic [31:0] ABS_CMD0_ADDR  = 32'h2D8;
  localparam logic [31:0] ABS_CMD1_ADDR  = 32'h2E0;
  localparam logic [31:0] PROG_BASE      = 32'h340;
  localparam logic [31:0] PROG_END       = PROG_BASE + 32'(8 * ProgBufSize);
  localparam logic [31:0] DATA_BASE      = 32'h380;
  localparam logic [31:0] DATA_END       = DATA_BASE + 32'(4 * DataCount);
  localparam logic [31:0] FLAGS_BASE     = 32'h400;
  localparam logic [31:0] FLAGS_LAST     = 32'h7FF;

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q;
  logic [31:0] addr_ext;
  logic        rd_hit;
  logic        any_hit;

  // Zero-extend so every compare sees the full address with no aliasing.
  assign addr_ext = 32'(addr_i);
  assign gnt_o    = req_i & ~rst_i;

  // NOTE: every output of this block gets a default before the decode so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_halted_en_o    = 1'b0;
    wr_going_en_o     = 1'b0;
    wr_resuming_en_o  = 1'b0;
    wr_exception_en_o = 1'b0;
    wr_data_en_o      = 1'b0;
    rd_where_en_o     = 1'b0;
    rd_data_en_o      = 1'b0;
    rd_prog_en_o      = 1'b0;
    rd_abs_cmd_en_o   = 1'b0;
    rd_flags_en_o     = 1'b0;
    addr_o            = '0;
    wdata_o           = '0;
    be_o              = '0;
    if (gnt_o) begin
      addr_o  = addr_i;
      wdata_o = wdata_i;
      be_o    = be_i;
      if (we_i) begin
        wr_halted_en_o    = (addr_ext == HALTED_ADDR);
        wr_going_en_o     = (addr_ext == GOING_ADDR);
        wr_resuming_en_o  = (addr_ext == RESUMING_ADDR);
        wr_exception_en_o = (addr_ext == EXCEPTION_ADDR);
        wr_data_en_o      = (addr_ext >= DATA_BASE) && (addr_ext < DATA_END)
                            && (addr_ext[1:0] == 2'b00);
      end else begin
        rd_where_en_o   = (addr_ext == WHERE_ADDR);
        rd_abs_cmd_en_o = (addr_ext == ABS_CMD0_ADDR) || (addr_ext == ABS_CMD1_ADDR);
        rd_prog_en_o    = (addr_ext >= PROG_BASE) && (addr_ext < PROG_END)
                          && (addr_ext[2:0] == 3'b000);
        // A 64-bit data read needs both 32-bit halves inside the data window.
        rd_data_en_o    = (addr_ext >= DATA_BASE) && (addr_ext + 32'd4 < DATA_END)
                          && (addr_ext[2:0] == 3'b000);
        rd_flags_en_o   = (addr_ext >= FLAGS_BASE) && (addr_ext <= FLAGS_LAST);
      end
    end
  end

  assign rd_hit  = rd_where_en_o | rd_data_en_o | rd_prog_en_o | rd_abs_cmd_en_o
                 | rd_flags_en_o;
  assign any_hit = rd_hit | wr_halted_en_o | wr_going_en_o | wr_resuming_en_o
                 | wr_exception_en_o | wr_data_en_o;

  // NOTE: reset is sampled on the clock edge here, so it lives inside the
  // clocked branch rather than in the sensitivity list; <= keeps all state
  // updates simultaneous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rvalid_o     <= 1'b0;
      rdata_o      <= '0;
      err_o        <= 1'b0;
      exc_sticky_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (gnt_o) state_q <= RESP;
        RESP:    state_q <= gnt_o ? RESP : IDLE;
        default: state_q <= IDLE;
      endcase
      rvalid_o <= gnt_o;
      if (gnt_o) begin
        rdata_o <= rd_hit ? dp_rdata_i : 64'd0;
        err_o   <= ~any_hit;
      end
      // Set has priority so an exception is never lost to a concurrent clear.
      if (gnt_o && wr_exception_en_o) exc_sticky_o <= 1'b1;
      else if (clr_exc_i)             exc_sticky_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_mem_bus_decoder.sv
// Scoreboard bench for dm_mem_bus_decoder: a driver issues directed and random
// requests and queues expectations; a monitor compares responses as they appear.
module tb_dm_mem_bus_decoder;

  localparam int unsigned AW = 12;
  localparam int unsigned DC = 2;
  localparam int unsigned PB = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [3:0]    be_i = '0;
  logic [63:0]   dp_rdata_i = '0;
  logic          clr_exc_i = 1'b0;
  logic          gnt_o, rvalid_o, err_o, exc_sticky_o;
  logic [63:0]   rdata_o;
  logic          wr_halted_en_o, wr_going_en_o, wr_resuming_en_o, wr_exception_en_o;
  logic          wr_data_en_o, rd_where_en_o, rd_data_en_o, rd_prog_en_o;
  logic          rd_abs_cmd_en_o, rd_flags_en_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic [3:0]    be_o;

  dm_mem_bus_decoder #(.DbgAddressBits(AW), .DataCount(DC), .ProgBufSize(PB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .wr_halted_en_o(wr_halted_en_o), .wr_going_en_o(wr_going_en_o),
    .wr_resuming_en_o(wr_resuming_en_o), .wr_exception_en_o(wr_exception_en_o),
    .wr_data_en_o(wr_data_en_o), .rd_where_en_o(rd_where_en_o),
    .rd_data_en_o(rd_data_en_o), .rd_prog_en_o(rd_prog_en_o),
    .rd_abs_cmd_en_o(rd_abs_cmd_en_o), .rd_flags_en_o(rd_flags_en_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .dp_rdata_i(dp_rdata_i),
    .exc_sticky_o(exc_sticky_o), .clr_exc_i(clr_exc_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned due;
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    int unsigned due;
    logic        value;
  } sticky_t;

  resp_t       resp_q[$];
  sticky_t     sticky_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic        model_sticky = 1'b0;
  bit          armed = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference map: enumerates the legal addresses of each region directly.
  // Bit order: halted, going, resuming, exception, wr_data, where, rd_data,
  // prog, abs_cmd, flags.
  function automatic logic [9:0] model_strobes(input logic we, input int unsigned a);
    logic [9:0] s;
    s = '0;
    if (we) begin
      s[9] = (a == 'h100);
      s[8] = (a == 'h108);
      s[7] = (a == 'h110);
      s[6] = (a == 'h118);
      for (int i = 0; i < DC; i++) if (a == 'h380 + 4 * i) s[5] = 1'b1;
    end else begin
      s[4] = (a == 'h300);
      for (int i = 0; i + 1 < DC; i += 2) if (a == 'h380 + 4 * i) s[3] = 1'b1;
      for (int i = 0; i < PB; i++) if (a == 'h340 + 8 * i) s[2] = 1'b1;
      s[1] = (a == 'h2D8) || (a == 'h2E0);
      s[0] = (a >= 'h400) && (a <= 'h7FF);
    end
    return s;
  endfunction

  task automatic drive(input bit req, input bit we, input logic [AW-1:0] a,
                       input bit clr, input bit rst, input logic [63:0] dp);
    logic       g;
    logic [9:0] s;
    resp_t      r;
    sticky_t    st;
    @(posedge clk_i);
    #1;
    req_i      = req;
    we_i       = we;
    addr_i     = a;
    clr_exc_i  = clr;
    rst_i      = rst;
    dp_rdata_i = dp;
    wdata_i    = $urandom;
    be_i       = 4'($urandom);
    g = req & ~rst;
    s = g ? model_strobes(we, int'(a)) : 10'd0;
    #1;
    check("gnt", 64'(gnt_o), 64'(g));
    check("strobes", 64'({wr_halted_en_o, wr_going_en_o, wr_resuming_en_o,
                          wr_exception_en_o, wr_data_en_o, rd_where_en_o,
                          rd_data_en_o, rd_prog_en_o, rd_abs_cmd_en_o,
                          rd_flags_en_o}), 64'(s));
    check("addr_o", 64'(addr_o), g ? 64'(a) : 64'd0);
    check("wdata_be", {28'd0, be_o, wdata_o}, g ? {28'd0, be_i, wdata_i} : 64'd0);
    if (g) begin
      r.due   = cyc + 1;
      r.rdata = (!we && s != 0) ? dp : 64'd0;
      r.err   = (s == 0);
      resp_q.push_back(r);
    end
    if (rst)                             model_sticky = 1'b0;
    else if (g && we && a == AW'('h118)) model_sticky = 1'b1;
    else if (clr)                        model_sticky = 1'b0;
    st.due   = cyc + 1;
    st.value = model_sticky;
    sticky_q.push_back(st);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    resp_t   r;
    sticky_t st;
    forever begin
      @(negedge clk_i);
      if (sticky_q.size() != 0 && sticky_q[0].due == cyc) begin
        st = sticky_q.pop_front();
        check("exc_sticky", 64'(exc_sticky_o), 64'(st.value));
        armed = 1'b1;
      end
      if (armed) begin
        if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
          r = resp_q.pop_front();
          check("rvalid", 64'(rvalid_o), 64'd1);
          check("rdata", rdata_o, r.rdata);
          check("err", 64'(err_o), 64'(r.err));
        end else begin
          check("rvalid_idle", 64'(rvalid_o), 64'd0);
        end
      end
    end
  end

  logic [AW-1:0] pool[22] = '{12'h100, 12'h104, 12'h108, 12'h110, 12'h118, 12'h11C,
                              12'h300, 12'h2D8, 12'h2E0, 12'h2DC, 12'h340, 12'h344,
                              12'h348, 12'h350, 12'h380, 12'h384, 12'h388, 12'h3FF,
                              12'h400, 12'h7FF, 12'h800, 12'h200};

  initial begin
    logic [AW-1:0] a;
    repeat (3) drive(0, 0, '0, 0, 1, '0);
    drive(0, 0, '0, 0, 0, '0);
    @(negedge clk_i);
    check("reset_rdata", rdata_o, 64'd0);
    check("reset_err", 64'(err_o), 64'd0);

    // Directed scenarios.
    drive(1, 1, 12'h100, 0, 0, 64'hDEAD_BEEF_0000_0001);
    drive(1, 0, 12'h300, 0, 0, 64'h6F);
    drive(1, 0, 12'h380, 0, 0, 64'h1122_3344_5566_7788);
    drive(1, 0, 12'h384, 0, 0, 64'hFFFF_0000_FFFF_0000);
    drive(1, 1, 12'h384, 0, 0, 64'h0);
    drive(1, 0, 12'h2D8, 0, 0, 64'hA5A5_A5A5_0000_0001);
    drive(1, 0, 12'h2E0, 0, 0, 64'h5A5A_5A5A_0000_0002);
    drive(0, 0, '0, 0, 0, '0);
    drive(1, 1, 12'h118, 0, 0, '0);
    drive(1, 1, 12'h118, 1, 0, '0);
    drive(0, 0, '0, 1, 0, '0);
    drive(0, 0, '0, 0, 0, '0);
    drive(1, 1, 12'h118, 0, 0, '0);
    drive(1, 0, 12'h200, 0, 0, 64'h1234);
    drive(1, 0, 12'h300, 0, 1, 64'h5678);
    drive(0, 0, '0, 0, 0, '0);
    drive(0, 0, '0, 0, 0, '0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 21)];
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
            {$urandom, $urandom});
    end

    repeat (3) drive(0, 0, '0, 0, 0, '0);
    @(negedge clk_i);
    check("queue_drained", 64'(resp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_mem_bus_decoder.md
Name: dm_mem_bus_decoder

Overview:
- Slave-side front end of the debug memory region; sits directly upstream of the debug memory read/write datapath.
- Accepts hart-side bus requests (req/gnt, one response per grant, no response backpressure).
- Decodes the address into one-hot write/read enables for the datapath.
- Registers the read data and produces the response phase, error and sticky status.

Parameters:
- DbgAddressBits, 12, width of addr_i and of the forwarded address.
- DataCount, 2, number of 32-bit data registers (0x380 + 4*i).
- ProgBufSize, 2, number of 64-bit program buffer read slots (0x340 + 8*i).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  bus request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  DbgAddressBits  byte address.
- wdata_i  in  32  write data, passed through to the datapath unchanged.
- be_i  in  4  byte enables, passed through to the datapath unchanged.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- rdata_o  out  64  response data.
- err_o  out  1  response error, qualified by rvalid_o.
- wr_halted_en_o, wr_going_en_o, wr_resuming_en_o, wr_exception_en_o, wr_data_en_o  out  1 each  write strobes.
- rd_where_en_o, rd_data_en_o, rd_prog_en_o, rd_abs_cmd_en_o, rd_flags_en_o  out  1 each  read strobes.
- addr_o  out  DbgAddressBits  forwarded address (wr/rd address).
- dp_rdata_i  in  64  combinational read data from the datapath.
- exc_sticky_o  out  1  set by an EXCEPTION write.
- clr_exc_i  in  1  clears exc_sticky_o.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Grant:
  - gnt_o = req_i & ~rst_i (combinational). A request is accepted every cycle, so back-to-back requests are allowed.
  - Strobes and addr_o = addr_i are combinational and valid only in the grant cycle. All strobes are 0 when no grant is given.
- Write map (we_i=1), exact address match unless noted:
  - 0x100 HALTED, 0x108 GOING, 0x110 RESUMING, 0x118 EXCEPTION.
  - DATA range 0x380 to 0x380+4*DataCount-1, word aligned.
- Read map (we_i=0):
  - 0x300 WHERETO.
  - ABS_CMD 0x2D8 and 0x2E0.
  - PROGBUF 0x340 to 0x340+8*ProgBufSize-1, 8-aligned.
  - DATA 0x380 to 0x380+4*DataCount-1, 8-aligned, and only if addr+4 is also inside the range.
  - FLAGS 0x400 to 0x7FF.
- Unmapped, misaligned or wrong-direction access: no strobe; the response carries err=1 and rdata=0.
- Response pipeline:
  - 2-state FSM: IDLE -> RESP on any grant.
  - RESP -> RESP on a new grant; otherwise RESP -> IDLE.
  - rvalid_o is 1 exactly one cycle after each grant.
  - rdata_o is dp_rdata_i sampled at the end of the grant cycle for reads; it is 0 for writes.
  - err_o is registered alongside rdata_o.
- rdata_o holds its last value when rvalid_o=0.
- exc_sticky_o:
  - Set the cycle after an EXCEPTION write grant.
  - Cleared the cycle after clr_exc_i.
  - Set wins over a simultaneous clear.
- Reset mid-operation: a pending response is dropped (rvalid_o=0 the next cycle) and exc_sticky_o clears.
- Address compare uses full DbgAddressBits; no wrap-around aliasing.

Test Plan:
- Write 0x100 (HALTED) -> gnt_o=1; wr_halted_en_o pulses 1 cycle; next cycle rvalid_o=1, err_o=0, rdata_o=0.
- Read 0x300 with dp_rdata_i=0x6F -> rd_where_en_o in grant cycle; next cycle rdata_o=0x000000000000006F, rvalid_o=1.
- DataCount=2:
  - Read 0x380 -> rd_data_en_o=1.
  - Read 0x384 -> no strobe, err_o=1.
  - Write 0x384, be=0xF -> wr_data_en_o=1, addr_o=0x384.
- Back-to-back reads 0x2D8 then 0x2E0 with distinct dp_rdata_i values -> rvalid_o high 2 consecutive cycles, data in order; FSM stays in RESP.
- Write 0x118 then clr_exc_i in the same cycle as a second EXCEPTION write -> exc_sticky_o stays 1; clr_exc_i alone -> 0 the next cycle.
- Read 0x200 (unmapped) followed by rst_i=1 the next cycle -> grant-cycle strobes 0; the cycle after reset rvalid_o=0, exc_sticky_o=0.
